// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states and the
// channel-ID header byte format.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_DRAIN
  } arb_state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;

  function automatic logic [7:0] hdrByte(input logic [2:0] id);
    return {HDR_TAG, 1'b0, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after the
// pointer, wrapping modulo NUM_REQ, as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx
);

  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        o_grant[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ packetised byte streams: round-robin
// grants of whole packets (capped at MAX_BURST bytes), optional header byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter bit HDR_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid_in,
  input  logic [8*NUM_REQ-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]   req_last_in,
  output logic [NUM_REQ-1:0]   req_ready_out,
  output logic [NUM_REQ-1:0]   grant_out,
  output logic                 busy_out,
  output logic                 tx_dv_out,
  output logic [7:0]           tx_b_out,
  input  logic                 tx_active_in,
  input  logic                 tx_done_in
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t         r_state, w_nextState;
  logic [NUM_REQ-1:0] r_grant, w_nextGrant, w_arbGrant;
  logic [IW-1:0]      r_gntIdx, w_nextGntIdx, w_arbIdx;
  logic [IW-1:0]      r_rrPtr, w_nextPtr;
  logic [CW-1:0]      r_byteCnt, w_nextCnt;
  logic               r_hdrFlag, w_nextHdr;
  logic               r_lastFlag, w_nextLast;
  logic               r_txDv, w_nextTxDv;
  logic [7:0]         r_txB, w_nextTxB;
  logic               w_accept;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_rr (
    .i_req  (req_valid_in),
    .i_ptr  (r_rrPtr),
    .o_grant(w_arbGrant),
    .o_idx  (w_arbIdx)
  );

  assign w_accept      = (r_state == ST_LOAD) && |(r_grant & req_valid_in);
  assign req_ready_out = (r_state == ST_LOAD) ? (r_grant & req_valid_in) : '0;
  assign grant_out     = r_grant;
  assign tx_dv_out     = r_txDv;
  assign tx_b_out      = r_txB;
  // DRAIN only waits out a frame left over from before reset, so it is not a packet of ours.
  assign busy_out      = (r_state != ST_IDLE) && (r_state != ST_DRAIN);

  always_comb begin
    w_nextState  = r_state;
    w_nextGrant  = r_grant;
    w_nextGntIdx = r_gntIdx;
    w_nextPtr    = r_rrPtr;
    w_nextCnt    = r_byteCnt;
    w_nextHdr    = r_hdrFlag;
    w_nextLast   = r_lastFlag;
    w_nextTxB    = r_txB;
    w_nextTxDv   = 1'b0;
    case (r_state)
      ST_DRAIN: begin
        if (!tx_active_in) w_nextState = ST_IDLE;
      end
      ST_IDLE: begin
        if (|req_valid_in && !tx_active_in) begin
          w_nextGrant  = w_arbGrant;
          w_nextGntIdx = w_arbIdx;
          w_nextCnt    = '0;
          w_nextState  = HDR_EN ? ST_HDR : ST_LOAD;
        end
      end
      ST_HDR: begin
        w_nextTxB   = hdrByte(3'(r_gntIdx));
        w_nextTxDv  = 1'b1;
        w_nextHdr   = 1'b1;
        w_nextState = ST_WAIT_DONE;
      end
      ST_LOAD: begin
        if (w_accept) begin
          w_nextTxB   = req_data_in[int'(r_gntIdx)*8 +: 8];
          w_nextTxDv  = 1'b1;
          w_nextLast  = req_last_in[r_gntIdx];
          w_nextCnt   = r_byteCnt + 1'b1;
          w_nextState = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done_in) begin
          if (r_hdrFlag) begin
            w_nextHdr   = 1'b0;
            w_nextState = ST_LOAD;
          end else if (r_lastFlag || (r_byteCnt == CW'(MAX_BURST))) begin
            w_nextGrant = '0;
            w_nextPtr   = (r_gntIdx == IW'(NUM_REQ - 1)) ? '0 : r_gntIdx + 1'b1;
            w_nextState = ST_IDLE;
          end else begin
            w_nextState = ST_LOAD;
          end
        end
      end
      default: w_nextState = ST_DRAIN;
    endcase
  end

  // Reset lands in DRAIN so a frame still shifting out of uart_tx is never overlapped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_DRAIN;
      r_grant    <= '0;
      r_gntIdx   <= '0;
      r_rrPtr    <= '0;
      r_byteCnt  <= '0;
      r_hdrFlag  <= 1'b0;
      r_lastFlag <= 1'b0;
      r_txB      <= '0;
      r_txDv     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_grant    <= w_nextGrant;
      r_gntIdx   <= w_nextGntIdx;
      r_rrPtr    <= w_nextPtr;
      r_byteCnt  <= w_nextCnt;
      r_hdrFlag  <= w_nextHdr;
      r_lastFlag <= w_nextLast;
      r_txB      <= w_nextTxB;
      r_txDv     <= w_nextTxDv;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural uart_tx models capture every
// started byte together with the grant, and streams are compared to hand-built lists.
module tb_uart_tx_arbiter;

  localparam int FRAME = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Main instance: 4 requesters, burst 16, headers on
  logic [3:0]  reqValid = '0;
  logic [31:0] reqData  = '0;
  logic [3:0]  reqLast  = '0;
  logic [3:0]  reqReady, grant;
  logic        busy, txDv;
  logic [7:0]  txB;
  logic        txActive = 1'b0;
  logic        txDone   = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(16), .HDR_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(reqValid), .req_data_in(reqData), .req_last_in(reqLast),
    .req_ready_out(reqReady), .grant_out(grant), .busy_out(busy),
    .tx_dv_out(txDv), .tx_b_out(txB),
    .tx_active_in(txActive), .tx_done_in(txDone)
  );

  // Second instance: 2 requesters, burst 2, no headers
  logic [1:0]  reqValid1 = '0;
  logic [15:0] reqData1  = '0;
  logic [1:0]  reqLast1  = '0;
  logic [1:0]  reqReady1, grant1;
  logic        busy1, txDv1;
  logic [7:0]  txB1;
  logic        txActive1 = 1'b0;
  logic        txDone1   = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(2), .MAX_BURST(2), .HDR_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(reqValid1), .req_data_in(reqData1), .req_last_in(reqLast1),
    .req_ready_out(reqReady1), .grant_out(grant1), .busy_out(busy1),
    .tx_dv_out(txDv1), .tx_b_out(txB1),
    .tx_active_in(txActive1), .tx_done_in(txDone1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Producers: packet bytes {last,data}; stimulus only appends, driver only advances.
  logic [8:0] pMem [4][32];
  int         pLen [4] = '{default: 0};
  int         pPos [4] = '{default: 0};
  logic [3:0] accepted = '0;

  always @(posedge clk) accepted <= reqValid & reqReady;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accepted[i]) pPos[i] = pPos[i] + 1;
      reqValid[i]        = (pPos[i] < pLen[i]);
      reqData[8*i +: 8]  = pMem[i][pPos[i] & 31][7:0];
      reqLast[i]         = pMem[i][pPos[i] & 31][8];
    end
  end

  logic [8:0] q1Mem [8];
  int         q1Len = 0;
  int         q1Pos = 0;
  logic       acc1  = 1'b0;

  always @(posedge clk) acc1 <= reqValid1[1] & reqReady1[1];

  always @(negedge clk) begin
    if (acc1) q1Pos = q1Pos + 1;
    reqValid1 = {(q1Pos < q1Len), 1'b0};
    reqData1  = {q1Mem[q1Pos & 7][7:0], 8'h00};
    reqLast1  = {q1Mem[q1Pos & 7][8], 1'b0};
  end

  // uart_tx models: not reset by rst_n, so a frame keeps shifting across an arbiter reset.
  int          m0Cnt = 0;
  logic [7:0]  m0Byte = '0;
  logic [11:0] capQ[$];
  int          m1Cnt = 0;
  logic [9:0]  cap1Q[$];

  always @(posedge clk) begin
    txDone <= 1'b0;
    if (txActive) begin
      if (m0Cnt == 1) begin
        txActive <= 1'b0;
        txDone   <= 1'b1;
      end
      m0Cnt <= m0Cnt - 1;
    end else if (txDv) begin
      txActive <= 1'b1;
      m0Cnt    <= FRAME;
      m0Byte   <= txB;
      capQ.push_back({grant, txB});
    end
  end

  always @(posedge clk) begin
    txDone1 <= 1'b0;
    if (txActive1) begin
      if (m1Cnt == 1) begin
        txActive1 <= 1'b0;
        txDone1   <= 1'b1;
      end
      m1Cnt <= m1Cnt - 1;
    end else if (txDv1) begin
      txActive1 <= 1'b1;
      m1Cnt     <= FRAME;
      cap1Q.push_back({grant1, txB1});
    end
  end

  // Pulse width, no start while busy, and tx_b_out held until the done pulse.
  logic prevDv0   = 1'b0;
  logic prevDv1   = 1'b0;
  logic hadReset  = 1'b0;
  int   dvCount0  = 0;

  always @(negedge clk) begin
    if (prevDv0) checkOutput("dvWidth", 32'(txDv), 32'd0);
    if (prevDv1) checkOutput("dvWidth1", 32'(txDv1), 32'd0);
    if (txDv) begin
      checkOutput("dvWhileActive", 32'(txActive), 32'd0);
      dvCount0 = dvCount0 + 1;
      hadReset = 1'b0;
    end
    if (!rst_n) hadReset = 1'b1;
    if (txDone && !hadReset) checkOutput("txbStable", 32'(txB), 32'(m0Byte));
    prevDv0 = txDv;
    prevDv1 = txDv1;
  end

  logic [11:0] expQ[$];
  int          capBase = 0;

  task automatic applyStimulus(input int req, input logic [7:0] data, input logic last);
    pMem[req][pLen[req]] = {last, data};
    pLen[req] = pLen[req] + 1;
  endtask

  task automatic expectByte(input logic [3:0] g, input logic [7:0] b);
    expQ.push_back({g, b});
  endtask

  task automatic checkStream(input string tag);
    checkOutput({tag, "_len"}, 32'(capQ.size() - capBase), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (capBase + i < capQ.size())
        checkOutput($sformatf("%s_%0d", tag, i), 32'(capQ[capBase + i]), 32'(expQ[i]));
    end
    capBase = capQ.size();
    expQ.delete();
  endtask

  function automatic bit allSent();
    for (int i = 0; i < 4; i++) if (pPos[i] < pLen[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while (!(allSent() && !busy && !txActive)) begin
      if (n == budget) begin
        checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
        break;
      end
      n++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int dvAtGap;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dv", 32'(txDv), 32'd0);
    checkOutput("rst_txb", 32'(txB), 32'd0);
    checkOutput("rst_ready", 32'(reqReady), 32'd0);
    checkOutput("rst_grant1", 32'(grant1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] test 1: single packet from req0");
    applyStimulus(0, 8'h11, 1'b0);
    applyStimulus(0, 8'h22, 1'b0);
    applyStimulus(0, 8'h33, 1'b1);
    waitIdle("t1", 2000);
    expectByte(4'h1, 8'hA0); expectByte(4'h1, 8'h11);
    expectByte(4'h1, 8'h22); expectByte(4'h1, 8'h33);
    checkStream("t1");
    checkOutput("t1_busyAfter", 32'(busy), 32'd0);
    checkOutput("t1_grantAfter", 32'(grant), 32'd0);

    $display("[TB] test 2: req0 and req2 together from pointer 0");
    applyReset();
    applyStimulus(0, 8'h01, 1'b0);
    applyStimulus(0, 8'h02, 1'b1);
    applyStimulus(2, 8'h21, 1'b0);
    applyStimulus(2, 8'h22, 1'b1);
    waitIdle("t2", 2000);
    expectByte(4'h1, 8'hA0); expectByte(4'h1, 8'h01); expectByte(4'h1, 8'h02);
    expectByte(4'h4, 8'hA2); expectByte(4'h4, 8'h21); expectByte(4'h4, 8'h22);
    checkStream("t2");
    // pointer is now 3: req3 must beat req1
    applyStimulus(1, 8'h31, 1'b1);
    applyStimulus(3, 8'h3F, 1'b1);
    waitIdle("t2b", 2000);
    expectByte(4'h8, 8'hA3); expectByte(4'h8, 8'h3F);
    expectByte(4'h2, 8'hA1); expectByte(4'h2, 8'h31);
    checkStream("t2b");

    $display("[TB] test 3: 20-byte packet against a 16-byte burst cap");
    for (int k = 0; k < 20; k++) applyStimulus(1, 8'(8'h40 + k), (k == 19));
    n = 0;
    while (grant != 4'b0010 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("t3_grant1", 32'(grant), 32'h2);
    applyStimulus(2, 8'h55, 1'b1);
    waitIdle("t3", 4000);
    expectByte(4'h2, 8'hA1);
    for (int k = 0; k < 16; k++) expectByte(4'h2, 8'(8'h40 + k));
    expectByte(4'h4, 8'hA2); expectByte(4'h4, 8'h55);
    expectByte(4'h2, 8'hA1);
    for (int k = 16; k < 20; k++) expectByte(4'h2, 8'(8'h40 + k));
    checkStream("t3");

    $display("[TB] test 4: req3 stalls mid-packet");
    applyStimulus(3, 8'h61, 1'b0);
    applyStimulus(3, 8'h62, 1'b0);
    n = 0;
    while (!(capQ.size() >= capBase + 3 && !txActive) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    dvAtGap = dvCount0;
    for (int k = 0; k < 5; k++) begin
      repeat (100) @(negedge clk);
      #1;
      checkOutput($sformatf("t4_grant_%0d", k), 32'(grant), 32'h8);
      checkOutput($sformatf("t4_ready_%0d", k), 32'(reqReady), 32'd0);
      checkOutput($sformatf("t4_busy_%0d", k), 32'(busy), 32'd1);
    end
    checkOutput("t4_noDv", 32'(dvCount0), 32'(dvAtGap));
    applyStimulus(3, 8'h63, 1'b0);
    applyStimulus(3, 8'h64, 1'b1);
    waitIdle("t4", 2000);
    expectByte(4'h8, 8'hA3); expectByte(4'h8, 8'h61); expectByte(4'h8, 8'h62);
    expectByte(4'h8, 8'h63); expectByte(4'h8, 8'h64);
    checkStream("t4");

    $display("[TB] test 5: reset in the middle of a data frame");
    applyStimulus(0, 8'h11, 1'b0);
    applyStimulus(0, 8'h22, 1'b0);
    applyStimulus(0, 8'h33, 1'b1);
    n = 0;
    while (!(capQ.size() >= capBase + 2 && txActive && m0Cnt == FRAME / 2) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("t5_dv", 32'(txDv), 32'd0);
    checkOutput("t5_grant", 32'(grant), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    dvAtGap = dvCount0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (txActive && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("t5_drained", 32'(txActive), 32'd0);
    checkOutput("t5_noDvInDrain", 32'(dvCount0), 32'(dvAtGap));
    waitIdle("t5", 2000);
    expectByte(4'h1, 8'hA0); expectByte(4'h1, 8'h11);
    expectByte(4'h1, 8'hA0); expectByte(4'h1, 8'h22); expectByte(4'h1, 8'h33);
    checkStream("t5");

    $display("[TB] test 6: no headers, burst cap of 2");
    q1Mem[0] = {1'b0, 8'h5A};
    q1Mem[1] = {1'b0, 8'h5B};
    q1Mem[2] = {1'b1, 8'h5C};
    q1Len = 3;
    repeat (3) @(negedge clk);
    n = 0;
    while (!(q1Pos >= 3 && !busy1 && !txActive1) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("t6_len", 32'(cap1Q.size()), 32'd3);
    if (cap1Q.size() >= 3) begin
      checkOutput("t6_0", 32'(cap1Q[0]), 32'h25A);
      checkOutput("t6_1", 32'(cap1Q[1]), 32'h25B);
      checkOutput("t6_2", 32'(cap1Q[2]), 32'h25C);
    end
    checkOutput("t6_grantAfter", 32'(grant1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
